// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - memory read and decode hand-off signals of fetch_ctrl
// master side belongs to fetch_ctrl; slave side to memory/decode.
interface fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output mem_req, mem_addr, ir, ir_valid,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir, ir_valid,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer driving PCreg via ldp/cta/SW
// IDLE -> FETCH -> HOLD -> ADV loop with redirect, flush and memory timeout.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] pc,
  output logic        ldp,
  output logic        cta,
  output logic [31:0] SW,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        err,
  output logic [31:0] fetch_cnt,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ADV   = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] sw_q, sw_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ir_q        <= '0;
      sw_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      sw_q        <= sw_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ir_d         = ir_q;
    sw_d         = sw_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    wait_d       = wait_q;
    err_d        = err_q;
    ldp          = 1'b0;
    cta          = 1'b0;
    SW           = sw_q;
    bus.mem_req  = 1'b0;
    bus.mem_addr = addr_q;
    bus.ir_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && !err_q) begin
          wait_d  = '0;
          // A redirect parked while idle is applied before any fetch from the stale PC.
          state_d = pend_q ? ADV : FETCH;
        end
      end

      FETCH: begin
        bus.mem_req = 1'b1;
        // PCreg settles on the ADV edge, so the address is taken live in the first cycle.
        if (wait_q == 8'd0) begin
          bus.mem_addr = pc;
          addr_d       = pc;
        end
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          wait_d  = '0;
          state_d = (pend_q || redirect) ? ADV : HOLD;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      HOLD: begin
        bus.ir_valid = 1'b1;
        if (bus.ir_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ADV;
        end else if (redirect) begin
          state_d = ADV;
        end
      end

      ADV: begin
        if (pend_q) begin
          ldp    = 1'b1;
          SW     = pend_addr_q;
          sw_d   = pend_addr_q;
          pend_d = 1'b0;
        end else begin
          cta = 1'b1;
        end
        wait_d  = '0;
        state_d = run ? FETCH : IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A fresh pulse always wins, including one arriving while ADV consumes the old one.
    if (redirect) begin
      pend_d      = 1'b1;
      pend_addr_d = redirect_addr;
    end
  end

  assign bus.ir    = ir_q;
  assign err       = err_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
// Includes a PCreg model and a memory with programmable wait states.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] pc;
  logic        ldp;
  logic        cta;
  logic [31:0] SW;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        err;
  logic [31:0] fetch_cnt;

  logic        ack_en;
  int          lat;
  int          req_age;
  int          checks;
  int          errors;
  int          n;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .pc            (pc),
    .ldp           (ldp),
    .cta           (cta),
    .SW            (SW),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .err           (err),
    .fetch_cnt     (fetch_cnt),
    .bus           (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst)     pc <= 32'd0;
    else if (ldp) pc <= SW;
    else if (cta) pc <= pc + 32'd1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst || !bus.mem_req) req_age <= 0;
    else                      req_age <= req_age + 1;
  end

  assign bus.mem_ack   = bus.mem_req && ack_en && (req_age >= lat);
  assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    run           = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    ack_en        = 1'b1;
    lat           = 0;
    bus.ir_ready  = 1'b1;

    #3;
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_ldp_cta", {30'd0, ldp, cta}, 32'd0);
    check("rst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_sw", SW, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_ir", bus.ir, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);

    tick();
    rst = 1'b1;
    run = 1'b1;

    // sequential fetch, 3 cycles per instruction
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_mem_req", {31'd0, bus.mem_req}, 32'd1);
      check("seq_mem_addr", bus.mem_addr, 32'(i));
      tick();
      check("seq_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
      check("seq_ir", bus.ir, 32'(i) ^ 32'hA5A5_0000);
      check("seq_hold_no_cta", {31'd0, cta}, 32'd0);
      tick();
      check("seq_cta", {30'd0, ldp, cta}, 32'd1);
      check("seq_fetch_cnt", fetch_cnt, 32'(i + 1));
    end

    // decode backpressure for 6 HOLD cycles
    bus.ir_ready = 1'b0;
    tick();
    check("bp_mem_addr", bus.mem_addr, 32'd4);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("bp_ir_valid", {31'd0, bus.ir_valid}, 32'd1);
      check("bp_ir", bus.ir, 32'hA5A5_0004);
      check("bp_no_adv", {30'd0, ldp, cta}, 32'd0);
      check("bp_cnt_held", fetch_cnt, 32'd4);
      tick();
    end
    check("bp_still_valid", {31'd0, bus.ir_valid}, 32'd1);
    bus.ir_ready = 1'b1;
    tick();
    check("bp_cta", {30'd0, ldp, cta}, 32'd1);
    check("bp_fetch_cnt", fetch_cnt, 32'd5);

    // redirect while memory stalls 3 cycles
    lat = 3;
    tick();
    check("rf_mem_addr", bus.mem_addr, 32'd5);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_FFFF;
    tick();
    redirect = 1'b0;
    check("rf_still_req", {31'd0, bus.mem_req}, 32'd1);
    check("rf_addr_stable", bus.mem_addr, 32'd5);
    tick();
    tick();
    check("rf_ack", {31'd0, bus.mem_ack}, 32'd1);
    tick();
    check("rf_ldp", {30'd0, ldp, cta}, 32'd2);
    check("rf_sw", SW, 32'h0000_FFFF);
    check("rf_no_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("rf_cnt", fetch_cnt, 32'd5);
    tick();
    lat = 0;
    check("rf_next_addr", bus.mem_addr, 32'h0000_FFFF);

    // redirect coinciding with accept
    tick();
    check("ra_ir", bus.ir, 32'hA5A5_FFFF);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check("ra_cnt", fetch_cnt, 32'd6);
    check("ra_ldp", {30'd0, ldp, cta}, 32'd2);
    check("ra_sw", SW, 32'h0000_0100);
    tick();
    check("ra_next_addr", bus.mem_addr, 32'h0000_0100);

    // run dropped during HOLD
    tick();
    bus.ir_ready = 1'b0;
    run          = 1'b0;
    tick();
    check("stop_hold", {31'd0, bus.ir_valid}, 32'd1);
    bus.ir_ready = 1'b1;
    tick();
    check("stop_cta", {30'd0, ldp, cta}, 32'd1);
    check("stop_cnt", fetch_cnt, 32'd7);
    tick();
    check("stop_idle", {29'd0, bus.mem_req, ldp, cta}, 32'd0);
    tick();
    check("stop_idle2", {30'd0, bus.mem_req, bus.ir_valid}, 32'd0);
    check("stop_sw_held", SW, 32'h0000_0100);

    // redirect parked in IDLE
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("ri_idle", {31'd0, bus.mem_req}, 32'd0);
    run = 1'b1;
    tick();
    check("ri_ldp", {29'd0, bus.mem_req, ldp, cta}, 32'd2);
    check("ri_sw", SW, 32'h0000_0200);
    tick();
    check("ri_addr", bus.mem_addr, 32'h0000_0200);
    tick();
    tick();
    check("ri_cta", {30'd0, ldp, cta}, 32'd1);
    check("ri_cnt", fetch_cnt, 32'd8);

    // memory timeout
    ack_en = 1'b0;
    tick();
    n = 0;
    while (bus.mem_req && n < 20) begin
      n++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd4);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_no_adv", {30'd0, ldp, cta}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("to_no_req", {31'd0, bus.mem_req}, 32'd0);
    end
    check("to_err_sticky", {31'd0, err}, 32'd1);

    // async reset mid-FETCH
    rst    = 1'b0;
    #2;
    check("to_err_cleared", {31'd0, err}, 32'd0);
    rst    = 1'b1;
    ack_en = 1'b1;
    tick();
    check("rs_addr0", bus.mem_addr, 32'd0);
    tick();
    tick();
    check("rs_cta", {30'd0, ldp, cta}, 32'd1);
    check("rs_cnt", fetch_cnt, 32'd1);
    lat = 5;
    tick();
    check("rs_fetch", {31'd0, bus.mem_req}, 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("ar_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("ar_ldp_cta", {30'd0, ldp, cta}, 32'd0);
    check("ar_fetch_cnt", fetch_cnt, 32'd0);
    check("ar_err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
